// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: run/step controller that generates the core reset and clock enable.
// Optional auto-halt at MAX_CYCLES retired cycles: define RUN_CTRL_LIMIT_EN.
module riscv_run_ctrl #(
    parameter int RST_HOLD   = 4,
    parameter int CNT_W      = 32,
    parameter int STEP_W     = 8,
    parameter int MAX_CYCLES = 1000
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              soft_rst_req,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_n,
    output logic              core_rst,
    output logic              core_ce,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              step_done,
    output logic              halted,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_RESET_HOLD,
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALTED
    } state_t;

    localparam logic [7:0]       HOLD_INIT = 8'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
`ifdef RUN_CTRL_LIMIT_EN
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CYCLES);
`endif

    state_t            r_state, w_nextState;
    logic [7:0]        r_holdCnt, w_nextHold;
    logic [STEP_W-1:0] r_stepCnt, w_nextStep;
    logic [CNT_W-1:0]  r_cycleCount, w_countInc, w_nextCount;
    logic              r_coreRst, r_coreCe, r_stepDone, r_busy;
    logic              w_nextStepDone;
`ifdef RUN_CTRL_LIMIT_EN
    logic              r_halted, w_nextHalted;
`endif

    always_comb begin
        w_countInc = r_cycleCount;
        if (r_coreCe && (r_cycleCount != CNT_SAT))
            w_countInc = r_cycleCount + CNT_W'(1);

        w_nextState    = r_state;
        w_nextHold     = r_holdCnt;
        w_nextStep     = r_stepCnt;
        w_nextCount    = w_countInc;
        w_nextStepDone = 1'b0;
`ifdef RUN_CTRL_LIMIT_EN
        w_nextHalted   = r_halted;
`endif

        case (r_state)
            S_RESET_HOLD: begin
                if (r_holdCnt == 8'd0)
                    w_nextState = S_IDLE;
                else
                    w_nextHold = r_holdCnt - 8'd1;
            end
            S_IDLE: begin
                if (run_req) begin
                    w_nextState = S_RUN;
                end else if (step_req) begin
                    w_nextState = S_STEP;
                    w_nextStep  = (step_n == '0) ? STEP_W'(1) : step_n;
                end
            end
            S_RUN: begin
                if (halt_req)
                    w_nextState = S_IDLE;
            end
            S_STEP: begin
                if (halt_req) begin
                    w_nextState = S_IDLE;
                end else if (r_stepCnt == STEP_W'(1)) begin
                    w_nextState    = S_IDLE;
                    w_nextStepDone = 1'b1;
                end else begin
                    w_nextStep = r_stepCnt - STEP_W'(1);
                end
            end
            S_HALTED: begin
                w_nextState = S_HALTED;
            end
            default: begin
                w_nextState = S_RESET_HOLD;
                w_nextHold  = HOLD_INIT;
            end
        endcase

`ifdef RUN_CTRL_LIMIT_EN
        // The limit takes precedence over halt and step completion in the same cycle
        if (r_coreCe && (r_cycleCount != CNT_LIMIT) && (w_countInc == CNT_LIMIT)) begin
            w_nextState    = S_HALTED;
            w_nextHalted   = 1'b1;
            w_nextStepDone = 1'b0;
        end
`endif

        if (soft_rst_req) begin
            w_nextState    = S_RESET_HOLD;
            w_nextHold     = HOLD_INIT;
            w_nextCount    = '0;
            w_nextStepDone = 1'b0;
`ifdef RUN_CTRL_LIMIT_EN
            w_nextHalted   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= S_RESET_HOLD;
            r_holdCnt    <= HOLD_INIT;
            r_stepCnt    <= '0;
            r_cycleCount <= '0;
            r_coreRst    <= 1'b1;
            r_coreCe     <= 1'b0;
            r_stepDone   <= 1'b0;
            r_busy       <= 1'b1;
`ifdef RUN_CTRL_LIMIT_EN
            r_halted     <= 1'b0;
`endif
        end else begin
            r_state      <= w_nextState;
            r_holdCnt    <= w_nextHold;
            r_stepCnt    <= w_nextStep;
            r_cycleCount <= w_nextCount;
            r_stepDone   <= w_nextStepDone;
            r_coreRst    <= (w_nextState == S_RESET_HOLD);
            r_coreCe     <= (w_nextState == S_RUN) || (w_nextState == S_STEP);
            r_busy       <= (w_nextState == S_RESET_HOLD) || (w_nextState == S_RUN) ||
                            (w_nextState == S_STEP);
`ifdef RUN_CTRL_LIMIT_EN
            r_halted     <= w_nextHalted;
`endif
        end
    end

    assign core_rst    = r_coreRst;
    assign core_ce     = r_coreCe;
    assign cycle_count = r_cycleCount;
    assign step_done   = r_stepDone;
    assign busy        = r_busy;
`ifdef RUN_CTRL_LIMIT_EN
    assign halted      = r_halted;
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// tb_riscv_run_ctrl: directed stimulus against a phase-level model of the run/step controller.
// Works with or without RUN_CTRL_LIMIT_EN; the limit and saturation sections adapt to the build.
module tb_riscv_run_ctrl;

    localparam int     TB_RST_HOLD = 4;
    localparam int     TB_CNT_W    = 5;
    localparam int     TB_STEP_W   = 8;
    localparam int     TB_MAX      = 20;
    localparam longint SAT         = (64'd1 << TB_CNT_W) - 1;

    localparam int PH_HOLD = 0;
    localparam int PH_IDLE = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_STEP = 3;
    localparam int PH_HALT = 4;

    logic                 clock = 1'b0;
    logic                 rst = 1'b1;
    logic                 soft_rst_req = 1'b0;
    logic                 run_req = 1'b0;
    logic                 halt_req = 1'b0;
    logic                 step_req = 1'b0;
    logic [TB_STEP_W-1:0] step_n = '0;
    logic                 core_rst, core_ce, step_done, halted, busy;
    logic [TB_CNT_W-1:0]  cycle_count;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    int     mPhase = PH_HOLD;
    int     mHoldLeft = TB_RST_HOLD;
    int     mStepLeft = 0;
    longint mCount = 0;
    bit     mHalted = 1'b0;
    bit     mDone = 1'b0;

    riscv_run_ctrl #(
        .RST_HOLD  (TB_RST_HOLD),
        .CNT_W     (TB_CNT_W),
        .STEP_W    (TB_STEP_W),
        .MAX_CYCLES(TB_MAX)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .soft_rst_req(soft_rst_req),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .step_n      (step_n),
        .core_rst    (core_rst),
        .core_ce     (core_ce),
        .cycle_count (cycle_count),
        .step_done   (step_done),
        .halted      (halted),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: tracks which phase the controller is in and how many cycles each phase has left
    always @(posedge clock) begin : model
        bit     ceBefore;
        longint prev;
        mDone    = 1'b0;
        ceBefore = (mPhase == PH_RUN) || (mPhase == PH_STEP);
        prev     = mCount;
        if (ceBefore)
            mCount = (mCount < SAT) ? mCount + 1 : SAT;
        if (rst || soft_rst_req) begin
            mPhase    = PH_HOLD;
            mHoldLeft = TB_RST_HOLD;
            mCount    = 0;
            mHalted   = 1'b0;
        end
`ifdef RUN_CTRL_LIMIT_EN
        else if (ceBefore && prev < TB_MAX && mCount == TB_MAX) begin
            mPhase  = PH_HALT;
            mHalted = 1'b1;
        end
`endif
        else begin
            case (mPhase)
                PH_HOLD: begin
                    mHoldLeft = mHoldLeft - 1;
                    if (mHoldLeft == 0) mPhase = PH_IDLE;
                end
                PH_IDLE: begin
                    if (run_req) mPhase = PH_RUN;
                    else if (step_req) begin
                        mPhase    = PH_STEP;
                        mStepLeft = (step_n == 0) ? 1 : int'(step_n);
                    end
                end
                PH_RUN: if (halt_req) mPhase = PH_IDLE;
                PH_STEP: begin
                    if (halt_req) mPhase = PH_IDLE;
                    else begin
                        mStepLeft = mStepLeft - 1;
                        if (mStepLeft == 0) begin
                            mPhase = PH_IDLE;
                            mDone  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("m_core_rst", core_rst, (mPhase == PH_HOLD));
            checkOutput("m_core_ce", core_ce, (mPhase == PH_RUN) || (mPhase == PH_STEP));
            checkOutput("m_busy", busy, (mPhase == PH_HOLD) || (mPhase == PH_RUN) || (mPhase == PH_STEP));
            checkOutput("m_cycle_count", cycle_count, mCount);
            checkOutput("m_step_done", step_done, mDone);
            checkOutput("m_halted", halted, mHalted);
        end
    end

    task automatic applyStimulus(input logic sr, input logic run, input logic halt,
                                 input logic step, input logic [TB_STEP_W-1:0] n);
        soft_rst_req = sr;
        run_req      = run;
        halt_req     = halt;
        step_req     = step;
        step_n       = n;
        @(negedge clock);
        soft_rst_req = 1'b0;
        run_req      = 1'b0;
        halt_req     = 1'b0;
        step_req     = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic measureBurst(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!core_ce) break;
            n++;
            @(negedge clock);
        end
    endtask

    initial begin : stimulus
        int n;
        @(negedge clock);
        checkEn = 1'b1;
        @(negedge clock);
        checkOutput("rst_core_rst", core_rst, 1);
        checkOutput("rst_core_ce", core_ce, 0);
        checkOutput("rst_count", cycle_count, 0);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_halted", halted, 0);

        rst = 1'b0;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (core_rst) n++;
            else break;
        end
        checkOutput("hold_len", n, 4);
        checkOutput("hold_busy_after", busy, 0);

        applyStimulus(0, 0, 0, 1, 8'd3);
        measureBurst(n);
        checkOutput("step3_len", n, 3);
        checkOutput("step3_done", step_done, 1);
        checkOutput("step3_count", cycle_count, 3);

        applyStimulus(0, 0, 0, 1, 8'd0);
        measureBurst(n);
        checkOutput("step0_len", n, 1);
        checkOutput("step0_done", step_done, 1);
        checkOutput("step0_count", cycle_count, 4);

        applyStimulus(0, 1, 0, 0, 8'd0);
        waitCycles(9);
        applyStimulus(0, 0, 1, 0, 8'd0);
        checkOutput("halt_ce", core_ce, 0);
        checkOutput("halt_count", cycle_count, 14);

        applyStimulus(0, 1, 0, 0, 8'd0);
        waitCycles(2);
        applyStimulus(0, 1, 1, 0, 8'd0);
        checkOutput("prio_halt_busy", busy, 0);
        checkOutput("prio_halt_count", cycle_count, 17);

        applyStimulus(0, 1, 0, 0, 8'd0);
        applyStimulus(0, 0, 0, 1, 8'd2);
        applyStimulus(0, 0, 1, 0, 8'd0);
        checkOutput("ignore_step_count", cycle_count, 19);
        applyStimulus(0, 0, 1, 0, 8'd0);
        checkOutput("idle_halt_busy", busy, 0);

        applyStimulus(0, 1, 0, 0, 8'd0);
        waitCycles(1);
        applyStimulus(1, 0, 1, 0, 8'd0);
        checkOutput("prio_soft_rst", core_rst, 1);
        checkOutput("prio_soft_count", cycle_count, 0);
        waitCycles(3);
        checkOutput("soft_hold_still", core_rst, 1);
        waitCycles(1);
        checkOutput("soft_hold_end", core_rst, 0);

        applyStimulus(0, 1, 0, 0, 8'd0);
        waitCycles(40);
`ifdef RUN_CTRL_LIMIT_EN
        checkOutput("limit_halted", halted, 1);
        checkOutput("limit_count", cycle_count, 20);
        checkOutput("limit_ce", core_ce, 0);
        applyStimulus(0, 1, 0, 0, 8'd0);
        checkOutput("limit_run_ignored", core_ce, 0);
`else
        checkOutput("sat_count", cycle_count, 31);
        checkOutput("sat_ce", core_ce, 1);
        applyStimulus(0, 0, 1, 0, 8'd0);
        checkOutput("sat_halt_count", cycle_count, 31);
`endif
        applyStimulus(1, 0, 0, 0, 8'd0);
        waitCycles(4);
        checkOutput("clear_halted", halted, 0);
        checkOutput("clear_busy", busy, 0);
        checkOutput("clear_count", cycle_count, 0);

        applyStimulus(0, 0, 0, 1, 8'd100);
        waitCycles(5);
        rst = 1'b1;
        @(negedge clock);
        checkOutput("abort_core_rst", core_rst, 1);
        checkOutput("abort_ce", core_ce, 0);
        checkOutput("abort_done", step_done, 0);
        checkOutput("abort_count", cycle_count, 0);
        rst = 1'b0;
        waitCycles(6);
        checkOutput("abort_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
